// File: rtl/ssd_scan_decoder.sv
// Receive side of an 8-digit multiplexed seven-segment display: watches the
// active-low anode/cathode scan, rebuilds the eight hex digits and flags illegal activity.
module ssd_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  An,
  input  logic [7:0]  Cathodes,
  output logic [31:0] Digits,
  output logic [7:0]  Dp_lit,
  output logic [7:0]  Digit_valid,
  output logic        Frame_done,
  output logic        Err,
  output logic [1:0]  Err_code
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD} state_e;
  typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_MULTI = 2'b01, ERR_SEG = 2'b10} err_e;

  logic [7:0]       an_q, cat_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lock_an_q, lock_an_d;
  logic [2:0]       lock_idx_q, lock_idx_d;
  logic [31:0]      digits_q, digits_d;
  logic [7:0]       dp_q, dp_d;
  logic [7:0]       valid_q, valid_d;
  logic [7:0]       mask_q, mask_d;
  logic             frame_q, frame_d;
  logic             err_q, err_d;
  err_e             err_code_q, err_code_d;

  logic [3:0] zero_cnt;
  logic [2:0] one_idx;
  logic       an_one, an_multi;
  logic       seg_legal;
  logic [3:0] seg_value;
  logic       capture;

  // Anode classification of the registered sample.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    zero_cnt = '0;
    one_idx  = '0;
    for (int i = 0; i < 8; i++) begin
      if (!an_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        one_idx  = 3'(i);
      end
    end
    an_one   = (zero_cnt == 4'd1);
    an_multi = (zero_cnt >= 4'd2);
  end

  always_comb begin
    seg_legal = 1'b1;
    seg_value = 4'h0;
    case (cat_q[7:1])
      7'b0000001: seg_value = 4'h0;
      7'b1001111: seg_value = 4'h1;
      7'b0010010: seg_value = 4'h2;
      7'b0000110: seg_value = 4'h3;
      7'b1001100: seg_value = 4'h4;
      7'b0100100: seg_value = 4'h5;
      7'b0100000: seg_value = 4'h6;
      7'b0001111: seg_value = 4'h7;
      7'b0000000: seg_value = 4'h8;
      7'b0000100: seg_value = 4'h9;
      7'b0001000: seg_value = 4'hA;
      7'b1100000: seg_value = 4'hB;
      7'b0110001: seg_value = 4'hC;
      7'b1000010: seg_value = 4'hD;
      7'b0110000: seg_value = 4'hE;
      7'b0111000: seg_value = 4'hF;
      default:    seg_legal = 1'b0;
    endcase
  end

  // Next-state logic: a dwell is captured once, then held until the anodes move.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_an_d  = lock_an_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      S_IDLE: begin
        if (an_one) begin
          state_d    = S_SETTLE;
          cnt_d      = CNT_W'(1);
          lock_an_d  = an_q;
          lock_idx_d = one_idx;
        end
      end
      S_SETTLE: begin
        if (an_q == lock_an_q) begin
          if (cnt_q == CNT_MAX) state_d = S_CAPTURE;
          else                  cnt_d   = cnt_q + CNT_W'(1);
        end else if (an_one) begin
          cnt_d      = CNT_W'(1);
          lock_an_d  = an_q;
          lock_idx_d = one_idx;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_CAPTURE: state_d = S_HOLD;
      S_HOLD: begin
        if (an_q != lock_an_q) begin
          if (an_one) begin
            state_d    = S_SETTLE;
            cnt_d      = CNT_W'(1);
            lock_an_d  = an_q;
            lock_idx_d = one_idx;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign capture = (state_q == S_CAPTURE);

  always_comb begin
    digits_d   = digits_q;
    dp_d       = dp_q;
    valid_d    = valid_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    frame_d    = (mask_q == 8'hFF);
    mask_d     = frame_d ? 8'h00 : mask_q;
    if (capture) begin
      mask_d[lock_idx_q]  = 1'b1;
      dp_d[lock_idx_q]    = ~cat_q[0];
      valid_d[lock_idx_q] = seg_legal;
      if (seg_legal) digits_d[{lock_idx_q, 2'b00} +: 4] = seg_value;
    end
    // Only the first error is recorded; a coincident multi-anode wins.
    if (an_multi || (capture && !seg_legal)) begin
      err_d = 1'b1;
      if (err_code_q == ERR_NONE) err_code_d = an_multi ? ERR_MULTI : ERR_SEG;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      // NOTE: the digit store is reset along with control because its outputs must read 0 after reset.
      an_q       <= 8'hFF;
      cat_q      <= 8'hFF;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lock_an_q  <= 8'hFF;
      lock_idx_q <= '0;
      digits_q   <= '0;
      dp_q       <= '0;
      valid_q    <= '0;
      mask_q     <= '0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      an_q       <= An;
      cat_q      <= Cathodes;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_an_q  <= lock_an_d;
      lock_idx_q <= lock_idx_d;
      digits_q   <= digits_d;
      dp_q       <= dp_d;
      valid_q    <= valid_d;
      mask_q     <= mask_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign Digits      = digits_q;
  assign Dp_lit      = dp_q;
  assign Digit_valid = valid_q;
  assign Frame_done  = frame_q;
  assign Err         = err_q;
  assign Err_code    = err_code_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder: drives scan patterns on An/Cathodes and
// compares decoded digits, flags and frame pulses against hand-computed values.
module tb_ssd_scan_decoder;

  localparam int N = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  An;
  logic [7:0]  Cathodes;
  logic [31:0] Digits;
  logic [7:0]  Dp_lit;
  logic [7:0]  Digit_valid;
  logic        Frame_done;
  logic        Err;
  logic [1:0]  Err_code;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;

  ssd_scan_decoder #(.SETTLE_CYCLES(N)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .An          (An),
    .Cathodes    (Cathodes),
    .Digits      (Digits),
    .Dp_lit      (Dp_lit),
    .Digit_valid (Digit_valid),
    .Frame_done  (Frame_done),
    .Err         (Err),
    .Err_code    (Err_code)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (Frame_done === 1'b1) frame_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Active-low cathode pattern {abcdefg, dp} for a hex value.
  function automatic logic [7:0] cat_of(input logic [3:0] v, input logic dp_on);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001; 4'h1: s = 7'b1001111; 4'h2: s = 7'b0010010; 4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100; 4'h5: s = 7'b0100100; 4'h6: s = 7'b0100000; 4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000; 4'h9: s = 7'b0000100; 4'hA: s = 7'b0001000; 4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001; 4'hD: s = 7'b1000010; 4'hE: s = 7'b0110000; default: s = 7'b0111000;
    endcase
    return {s, ~dp_on};
  endfunction

  function automatic logic [7:0] an_of(input int idx);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << idx);
  endfunction

  task automatic show_digit(input int idx, input logic [7:0] cat, input int dwell);
    An       = an_of(idx);
    Cathodes = cat;
    repeat (dwell) @(negedge Clk);
  endtask

  task automatic full_scan(input logic [31:0] word);
    for (int i = 7; i >= 0; i--) show_digit(i, cat_of(word[i*4 +: 4], 1'b0), 64);
  endtask

  logic [31:0] scan_word;

  initial begin
    Reset    = 1'b1;
    An       = 8'hFF;
    Cathodes = 8'hFF;
    repeat (3) @(negedge Clk);
    check("reset_digits", Digits, 32'h0);
    check("reset_dp", Dp_lit, 8'h00);
    check("reset_valid", Digit_valid, 8'h00);
    check("reset_frame", Frame_done, 1'b0);
    check("reset_err", {Err, Err_code}, 3'b000);
    Reset = 1'b0;
    @(negedge Clk);

    // Latency: An is sampled on the first edge, then SETTLE_CYCLES+2 more edges to the update.
    scan_word = 32'h1234ABCD;
    An        = an_of(7);
    Cathodes  = cat_of(scan_word[31:28], 1'b0);
    repeat (N + 2) @(negedge Clk);
    check("latency_before", Digits[31:28], 4'h0);
    @(negedge Clk);
    check("latency_after", Digits[31:28], 4'h1);
    repeat (64 - N - 3) @(negedge Clk);
    for (int i = 6; i >= 0; i--) show_digit(i, cat_of(scan_word[i*4 +: 4], 1'b0), 64);
    check("scan1_digits", Digits, 32'h1234ABCD);
    check("scan1_valid", Digit_valid, 8'hFF);
    check("scan1_dp", Dp_lit, 8'h00);
    check("scan1_frames", frame_cnt, 1);
    check("scan1_err", {Err, Err_code}, 3'b000);

    full_scan(scan_word);
    check("scan2_digits", Digits, 32'h1234ABCD);
    check("scan2_frames", frame_cnt, 2);

    // Dwell one cycle short of the settle count on digit 2, then move on to digit 3.
    show_digit(2, cat_of(4'h5, 1'b0), N - 1);
    show_digit(3, cat_of(4'hE, 1'b0), 64);
    check("short_dwell_digits", Digits, 32'h1234EBCD);
    check("short_dwell_valid", Digit_valid, 8'hFF);

    show_digit(0, 8'b00011110, 64);
    check("dp_digit0", Digits[3:0], 4'h7);
    check("dp_lit", Dp_lit, 8'h01);
    check("dp_err", Err, 1'b0);

    An = 8'b11110011;
    @(negedge Clk);
    An = 8'hFF;
    repeat (3) @(negedge Clk);
    check("multi_err", Err, 1'b1);
    check("multi_code", Err_code, 2'b01);
    show_digit(6, 8'hFF, 64);
    check("bad_after_multi_code", Err_code, 2'b01);
    check("bad_after_multi_valid", Digit_valid, 8'hBF);
    check("bad_after_multi_digits", Digits, 32'h1234EBC7);
    check("frames_unchanged", frame_cnt, 2);

    // Reset lands on the edge where the settle counter would pass SETTLE_CYCLES-1.
    show_digit(1, cat_of(4'h9, 1'b0), N);
    Reset = 1'b1;
    @(negedge Clk);
    check("midsettle_digits", Digits, 32'h0);
    check("midsettle_flags", {Dp_lit, Digit_valid}, 16'h0000);
    check("midsettle_err", {Err, Err_code}, 3'b000);
    Reset = 1'b0;
    An    = 8'hFF;
    repeat (N + 4) @(negedge Clk);
    check("midsettle_no_capture", {Digits, Digit_valid}, 40'h0);

    show_digit(5, 8'hFF, 64);
    check("blank_valid", Digit_valid, 8'h00);
    check("blank_code", Err_code, 2'b10);
    check("blank_err", Err, 1'b1);
    check("blank_digits", Digits[23:20], 4'h0);
    check("blank_dp", Dp_lit, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
